stream_buffer: RTL and testbench
================================

# stream_buffer

Receive-side byte buffer sitting directly upstream of the terminal stream decoder. It absorbs bursts of bytes from the serial receiver into a circular FIFO and applies hardware flow control toward the host with hysteresis. It replays the bytes to the decoder as single-cycle `unicode_available` pulses, issued only while the decoder signals `ready_n` low. Without it, bytes arriving while the decoder is busy with SDRAM writes, scrolls or clears would be lost.

## Interface
- `DEPTH_LOG2`, 6, FIFO depth is 2^DEPTH_LOG2 bytes (64).
- `RTS_HIGH`, 48, fill level at or above which `rts_n` deasserts (stop sending).
- `RTS_LOW`, 16, fill level at or below which `rts_n` reasserts (resume). Must be less than `RTS_HIGH`.
- `clk`  in  1  single clock; everything is in this domain.
- `reset`  in  1  asynchronous, active-low reset.
- `rx_data`  in  8  byte from the serial receiver.
- `rx_available`  in  1  one-cycle strobe; `rx_data` is valid this cycle.
- `rts_n`  out  1  flow control to the host; 0 means send, 1 means stop.
- `ready_n`  in  1  from the decoder; 0 means it can accept a byte.
- `unicode`  out  8  byte presented to the decoder.
- `unicode_available`  out  1  one-cycle pulse qualifying `unicode`.
- `fill`  out  DEPTH_LOG2+1  current number of stored bytes.
- `overflow`  out  1  sticky flag; at least one byte was dropped.
- `overflow_clear`  in  1  clears `overflow`.

## Operation
- **Storage**
  - Circular buffer: `wr_ptr` and `rd_ptr`, each DEPTH_LOG2 bits, wrapping naturally modulo 2^DEPTH_LOG2.
  - `fill` is kept explicitly and updates as `fill + push - pop`.
  - Full means `fill == 2^DEPTH_LOG2`. Empty means `fill == 0`.
- **Push**
  - On a `rx_available` cycle, the byte is written at `wr_ptr` and `wr_ptr` increments, only if the buffer is not full.
  - Fullness is judged on the registered `fill`. A pop in the same cycle does not free space for that push.
  - If full, the byte is dropped, `overflow` is set, and `fill` and the pointers are unchanged by the push.
- **Overflow flag**
  - `overflow_clear` clears `overflow`.
  - If a drop and `overflow_clear` occur in the same cycle, set wins.
- **Output sequencer** (two states)
  - `S_IDLE`: `unicode_available` is 0. If `fill != 0` and `ready_n == 0`, then at the clock edge:
    - `unicode <= mem[rd_ptr]`;
    - `unicode_available <= 1`;
    - `rd_ptr` increments and the pop is counted in `fill`;
    - go to `S_SEND`.
  - Otherwise remain in `S_IDLE`.
  - `S_SEND`: `unicode_available <= 0`; go to `S_IDLE`. `ready_n` is ignored in this state, because the decoder updates it on the same edge that consumes the byte.
  - `unicode` holds its last value between pulses.
- **Simultaneous push and pop**
  - Both occur, and `fill` is unchanged.
  - A push into an empty buffer cannot pop in the same cycle. The earliest pop is the next cycle.
- **Flow control**
  - `rts_n` is registered from the registered `fill`.
  - Set to 1 when `fill >= RTS_HIGH`. Set to 0 when `fill <= RTS_LOW`. Hold otherwise (hysteresis).
- **Reset**
  - Asynchronous assertion at any time, including mid-pulse, discards all buffer contents.
  - Reset values: pointers 0, `fill` 0, state `S_IDLE`, `unicode` 8'h00, `unicode_available` 0, `rts_n` 0, `overflow` 0.
  - Memory contents need no reset.

## Timing
- All outputs are registered.
- **Latency**
  - `rx_available` at cycle t into an empty buffer, with `ready_n` low: `fill` = 1 at t+1, `unicode_available` high during t+2.
- **Throughput**
  - At most one byte every 2 cycles: pulse, then one `S_IDLE` cycle in which `ready_n` is sampled.
  - `unicode_available` is never high on two consecutive cycles.
- **Decoder busy**
  - If `ready_n` goes high after a pulse, no further pulse is issued until `ready_n` is sampled low in `S_IDLE`.
- `rts_n` lags the `fill` crossing by one cycle, and `fill` lags the push by one cycle.
- Pointer wrap from 2^DEPTH_LOG2-1 to 0 requires no special handling. Byte order is preserved across the wrap.

## Test plan
- **Basic pass-through**: push 0x41, 0x42, 0x43 on consecutive cycles with `ready_n` = 0 -> three `unicode_available` pulses carrying 0x41, 0x42, 0x43, spaced exactly 2 cycles apart; first pulse 2 cycles after the first push; `fill` returns to 0.
- **Backpressure**: hold `ready_n` = 1, push 10 bytes -> no pulses and `fill` = 10. Release `ready_n` -> all 10 bytes delivered in order.
- **Hysteresis**: with `ready_n` = 1, push 48 bytes -> `rts_n` rises 1 cycle after `fill` reaches 48. Drain to 17 -> `rts_n` still 1. Drain to 16 -> `rts_n` falls to 0.
- **Overflow**: with `ready_n` = 1, push 66 bytes -> `fill` = 64, `overflow` = 1, and bytes 65–66 are lost. Assert `overflow_clear` in the same cycle as a further push -> `overflow` stays 1. Assert `overflow_clear` alone -> `overflow` = 0.
- **Wrap and simultaneity**: stream 200 bytes (0x00 to 0xC7) while toggling `ready_n` pseudo-randomly -> output sequence is identical to input, with no loss or duplication, covering pointer wrap and same-cycle push/pop.
- **Async reset**: assert `reset` low during the `unicode_available` pulse with `fill` = 5 -> `unicode_available` drops to 0 immediately, with `fill` = 0, `rts_n` = 0 and `overflow` = 0. After release, no stale byte is emitted.

Source files
------------

// File: rtl/stream_buffer_if.sv
// stream_buffer_if: receiver, decoder and host-flow-control signals of the receive byte buffer.
interface stream_buffer_if #(parameter int DEPTH_LOG2 = 6);
    logic [7:0]          rx_data;
    logic                rx_available;
    logic                rts_n;
    logic                ready_n;
    logic [7:0]          unicode;
    logic                unicode_available;
    logic [DEPTH_LOG2:0] fill;
    logic                overflow;
    logic                overflow_clear;
    modport master (
        output rx_data, rx_available, ready_n, overflow_clear,
        input  rts_n, unicode, unicode_available, fill, overflow
    );
    modport slave (
        input  rx_data, rx_available, ready_n, overflow_clear,
        output rts_n, unicode, unicode_available, fill, overflow
    );
endinterface

// File: rtl/stream_buffer.sv
// stream_buffer: circular byte FIFO between serial receiver and decoder, with
// hysteretic RTS flow control and one-byte-per-two-cycle replay pulses.
module stream_buffer #(
    parameter int DEPTH_LOG2 = 6,
    parameter int RTS_HIGH   = 48,
    parameter int RTS_LOW    = 16
) (
    input logic           clk,
    input logic           reset,
    stream_buffer_if.slave bus
);
    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam int FW    = DEPTH_LOG2 + 1;

    typedef enum logic {S_IDLE, S_SEND} state_t;

    state_t                state_q, state_d;
    logic [7:0]            mem [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [FW-1:0]         fill_q, fill_d;
    logic [7:0]            unicode_q, unicode_d;
    logic                  avail_q, avail_d, rts_q, rts_d, ovf_q, ovf_d;
    logic                  push, pop, drop;

    // Fullness uses the registered fill, so a same-cycle pop never makes room.
    always_comb begin
        push      = bus.rx_available && fill_q != FW'(DEPTH);
        drop      = bus.rx_available && fill_q == FW'(DEPTH);
        pop       = state_q == S_IDLE && fill_q != '0 && !bus.ready_n;
        state_d   = pop ? S_SEND : S_IDLE;
        avail_d   = pop;
        unicode_d = pop ? mem[rd_ptr_q] : unicode_q;
        wr_ptr_d  = push ? wr_ptr_q + DEPTH_LOG2'(1) : wr_ptr_q;
        rd_ptr_d  = pop ? rd_ptr_q + DEPTH_LOG2'(1) : rd_ptr_q;
        fill_d    = fill_q + FW'(push) - FW'(pop);
        rts_d     = fill_q >= FW'(RTS_HIGH) ? 1'b1 : fill_q <= FW'(RTS_LOW) ? 1'b0 : rts_q;
        ovf_d     = drop ? 1'b1 : bus.overflow_clear ? 1'b0 : ovf_q;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= S_IDLE;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            fill_q    <= '0;
            unicode_q <= 8'h00;
            avail_q   <= 1'b0;
            rts_q     <= 1'b0;
            ovf_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            fill_q    <= fill_d;
            unicode_q <= unicode_d;
            avail_q   <= avail_d;
            rts_q     <= rts_d;
            ovf_q     <= ovf_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr_q] <= bus.rx_data;
    end

    assign bus.unicode           = unicode_q;
    assign bus.unicode_available = avail_q;
    assign bus.fill              = fill_q;
    assign bus.rts_n             = rts_q;
    assign bus.overflow          = ovf_q;
endmodule

// File: tb/tb_stream_buffer.sv
// tb_stream_buffer: randomized scenarios against a queue-based model of the byte buffer.
module tb_stream_buffer;
    localparam int DL    = 6;
    localparam int DEPTH = 64;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    stream_buffer_if #(.DEPTH_LOG2(DL)) bus ();
    stream_buffer #(.DEPTH_LOG2(DL), .RTS_HIGH(48), .RTS_LOW(16)) dut (
        .clk(clk), .reset(reset), .bus(bus)
    );

    int         n_cmp = 0;
    int         n_err = 0;
    logic [7:0] mq[$];
    logic       m_av  = 1'b0;
    logic       m_rts = 1'b0;
    logic       m_ovf = 1'b0;
    logic [7:0] m_uni = 8'h00;

    // One clock cycle: drive inputs, advance the model at the edge, return at the falling edge.
    task automatic tick(input logic av, input logic [7:0] d, input logic rdy, input logic clr);
        int sz;
        bit do_pop, do_push;
        bus.rx_available   = av;
        bus.rx_data        = d;
        bus.ready_n        = rdy;
        bus.overflow_clear = clr;
        @(posedge clk);
        sz      = mq.size();
        do_pop  = !m_av && sz > 0 && !rdy;
        do_push = av && sz < DEPTH;
        m_rts   = sz >= 48 ? 1'b1 : sz <= 16 ? 1'b0 : m_rts;
        m_ovf   = (av && sz == DEPTH) ? 1'b1 : clr ? 1'b0 : m_ovf;
        m_av    = do_pop;
        if (do_pop) m_uni = mq.pop_front();
        if (do_push) mq.push_back(d);
        @(negedge clk);
        bus.rx_available   = 1'b0;
        bus.overflow_clear = 1'b0;
    endtask

    task automatic model_clear();
        mq.delete();
        m_av  = 1'b0;
        m_rts = 1'b0;
        m_ovf = 1'b0;
        m_uni = 8'h00;
    endtask

    task automatic do_reset();
        bus.rx_available = 1'b0; bus.overflow_clear = 1'b0; bus.ready_n = 1'b1; bus.rx_data = 8'h00;
        reset = 1'b0;
        model_clear();
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_reset();
        bus.rx_available = 1'b0; bus.overflow_clear = 1'b0; bus.ready_n = 1'b1; bus.rx_data = 8'h00;
        reset = 1'b0;
        model_clear();
        repeat (2) @(negedge clk);
        n_cmp++; if (bus.fill !== 7'd0) begin n_err++; $display("FAIL reset_fill: got %0d want 0", bus.fill); end
        n_cmp++; if (bus.unicode_available !== 1'b0) begin n_err++; $display("FAIL reset_avail: got %b want 0", bus.unicode_available); end
        n_cmp++; if (bus.unicode !== 8'h00) begin n_err++; $display("FAIL reset_unicode: got %h want 00", bus.unicode); end
        n_cmp++; if (bus.rts_n !== 1'b0) begin n_err++; $display("FAIL reset_rts: got %b want 0", bus.rts_n); end
        n_cmp++; if (bus.overflow !== 1'b0) begin n_err++; $display("FAIL reset_ovf: got %b want 0", bus.overflow); end
        reset = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_pass_through();
        int         at[$];
        logic [7:0] got[$];
        logic [7:0] want;
        for (int i = 1; i <= 8; i++) begin
            tick(i <= 3, 8'(8'h40 + i), 1'b0, 1'b0);
            n_cmp++; if (bus.unicode_available !== m_av) begin n_err++; $display("FAIL pt_avail c%0d: got %b want %b", i, bus.unicode_available, m_av); end
            if (bus.unicode_available === 1'b1) begin at.push_back(i); got.push_back(bus.unicode); end
        end
        n_cmp++; if (at.size() != 3) begin n_err++; $display("FAIL pt_count: got %0d want 3", at.size()); end
        for (int k = 0; k < at.size() && k < 3; k++) begin
            want = 8'(8'h41 + k);
            n_cmp++; if (at[k] != 2 + 2 * k) begin n_err++; $display("FAIL pt_timing #%0d: got cycle %0d want %0d", k, at[k], 2 + 2 * k); end
            n_cmp++; if (got[k] !== want) begin n_err++; $display("FAIL pt_byte #%0d: got %h want %h", k, got[k], want); end
        end
        n_cmp++; if (bus.fill !== 7'd0) begin n_err++; $display("FAIL pt_fill: got %0d want 0", bus.fill); end
    endtask

    task automatic test_backpressure();
        logic [7:0] sent[$];
        logic [7:0] b;
        int         n = 0;
        for (int i = 0; i < 10; i++) begin
            b = 8'($urandom);
            sent.push_back(b);
            tick(1'b1, b, 1'b1, 1'b0);
            n_cmp++; if (bus.unicode_available !== 1'b0) begin n_err++; $display("FAIL bp_nopulse c%0d: got %b want 0", i, bus.unicode_available); end
        end
        tick(1'b0, 8'h00, 1'b1, 1'b0);
        n_cmp++; if (bus.fill !== 7'd10) begin n_err++; $display("FAIL bp_fill: got %0d want 10", bus.fill); end
        repeat (30) begin
            tick(1'b0, 8'h00, 1'b0, 1'b0);
            if (bus.unicode_available === 1'b1) begin
                n_cmp++; if (n >= 10 || bus.unicode !== sent[n]) begin n_err++; $display("FAIL bp_byte #%0d: got %h want %h", n, bus.unicode, n < 10 ? sent[n] : 8'hxx); end
                n++;
            end
        end
        n_cmp++; if (n != 10) begin n_err++; $display("FAIL bp_count: got %0d want 10", n); end
        n_cmp++; if (bus.fill !== 7'd0) begin n_err++; $display("FAIL bp_drained: got %0d want 0", bus.fill); end
    endtask

    task automatic test_hysteresis();
        for (int i = 0; i < 48; i++) tick(1'b1, 8'(i), 1'b1, 1'b0);
        n_cmp++; if (bus.fill !== 7'd48) begin n_err++; $display("FAIL hy_fill48: got %0d want 48", bus.fill); end
        n_cmp++; if (bus.rts_n !== 1'b0) begin n_err++; $display("FAIL hy_lag: got %b want 0", bus.rts_n); end
        tick(1'b0, 8'h00, 1'b1, 1'b0);
        n_cmp++; if (bus.rts_n !== 1'b1) begin n_err++; $display("FAIL hy_rise: got %b want 1", bus.rts_n); end
        while (mq.size() > 17) tick(1'b0, 8'h00, 1'b0, 1'b0);
        tick(1'b0, 8'h00, 1'b1, 1'b0);
        n_cmp++; if (bus.fill !== 7'd17) begin n_err++; $display("FAIL hy_fill17: got %0d want 17", bus.fill); end
        n_cmp++; if (bus.rts_n !== 1'b1) begin n_err++; $display("FAIL hy_hold17: got %b want 1", bus.rts_n); end
        while (mq.size() > 16) tick(1'b0, 8'h00, 1'b0, 1'b0);
        tick(1'b0, 8'h00, 1'b1, 1'b0);
        n_cmp++; if (bus.fill !== 7'd16) begin n_err++; $display("FAIL hy_fill16: got %0d want 16", bus.fill); end
        n_cmp++; if (bus.rts_n !== 1'b0) begin n_err++; $display("FAIL hy_fall16: got %b want 0", bus.rts_n); end
        repeat (40) tick(1'b0, 8'h00, 1'b0, 1'b0);
        n_cmp++; if (bus.fill !== 7'd0) begin n_err++; $display("FAIL hy_drained: got %0d want 0", bus.fill); end
    endtask

    task automatic test_overflow();
        logic [7:0] sent[$];
        logic [7:0] b;
        int         n = 0;
        for (int i = 0; i < 66; i++) begin
            b = 8'($urandom);
            if (i < DEPTH) sent.push_back(b);
            tick(1'b1, b, 1'b1, 1'b0);
        end
        n_cmp++; if (bus.fill !== 7'd64) begin n_err++; $display("FAIL ov_fill: got %0d want 64", bus.fill); end
        n_cmp++; if (bus.overflow !== 1'b1) begin n_err++; $display("FAIL ov_set: got %b want 1", bus.overflow); end
        tick(1'b1, 8'hEE, 1'b1, 1'b1);
        n_cmp++; if (bus.overflow !== 1'b1) begin n_err++; $display("FAIL ov_set_wins: got %b want 1", bus.overflow); end
        tick(1'b0, 8'h00, 1'b1, 1'b1);
        n_cmp++; if (bus.overflow !== 1'b0) begin n_err++; $display("FAIL ov_clear: got %b want 0", bus.overflow); end
        repeat (140) begin
            tick(1'b0, 8'h00, 1'b0, 1'b0);
            if (bus.unicode_available === 1'b1) begin
                n_cmp++; if (n >= DEPTH || bus.unicode !== sent[n]) begin n_err++; $display("FAIL ov_byte #%0d: got %h want %h", n, bus.unicode, n < DEPTH ? sent[n] : 8'hxx); end
                n++;
            end
        end
        n_cmp++; if (n != DEPTH) begin n_err++; $display("FAIL ov_count: got %0d want 64", n); end
    endtask

    task automatic test_wrap();
        logic [7:0] got[$];
        int         pushed = 0;
        int         cyc = 0;
        logic       av, prev_av = 1'b0;
        while ((pushed < 200 || mq.size() > 0 || m_av) && cyc < 3000) begin
            av = pushed < 200 && mq.size() < 60 && $urandom_range(0, 2) != 0;
            tick(av, 8'(pushed), 1'($urandom_range(0, 2) == 0), 1'b0);
            if (av) pushed++;
            cyc++;
            n_cmp++; if (bus.unicode_available !== m_av) begin n_err++; $display("FAIL wr_avail c%0d: got %b want %b", cyc, bus.unicode_available, m_av); end
            n_cmp++; if (bus.fill !== 7'(mq.size())) begin n_err++; $display("FAIL wr_fill c%0d: got %0d want %0d", cyc, bus.fill, mq.size()); end
            n_cmp++; if (bus.rts_n !== m_rts) begin n_err++; $display("FAIL wr_rts c%0d: got %b want %b", cyc, bus.rts_n, m_rts); end
            n_cmp++; if (bus.unicode !== m_uni) begin n_err++; $display("FAIL wr_unicode c%0d: got %h want %h", cyc, bus.unicode, m_uni); end
            n_cmp++; if (prev_av && bus.unicode_available === 1'b1) begin n_err++; $display("FAIL wr_b2b c%0d: got 1 want 0", cyc); end
            prev_av = bus.unicode_available;
            if (bus.unicode_available === 1'b1) got.push_back(bus.unicode);
        end
        n_cmp++; if (got.size() != 200) begin n_err++; $display("FAIL wr_count: got %0d want 200", got.size()); end
        for (int k = 0; k < got.size() && k < 200; k++) begin
            n_cmp++; if (got[k] !== 8'(k)) begin n_err++; $display("FAIL wr_order #%0d: got %h want %h", k, got[k], 8'(k)); end
        end
    endtask

    task automatic test_async_reset();
        int stale = 0;
        for (int i = 0; i < 6; i++) tick(1'b1, 8'(8'hA0 + i), 1'b1, 1'b0);
        tick(1'b0, 8'h00, 1'b0, 1'b0);
        n_cmp++; if (bus.unicode_available !== 1'b1 || bus.fill !== 7'd5) begin n_err++; $display("FAIL ar_setup: got avail %b fill %0d want 1 5", bus.unicode_available, bus.fill); end
        #1 reset = 1'b0;
        #1;
        n_cmp++; if (bus.unicode_available !== 1'b0) begin n_err++; $display("FAIL ar_avail: got %b want 0", bus.unicode_available); end
        n_cmp++; if (bus.fill !== 7'd0) begin n_err++; $display("FAIL ar_fill: got %0d want 0", bus.fill); end
        n_cmp++; if (bus.rts_n !== 1'b0) begin n_err++; $display("FAIL ar_rts: got %b want 0", bus.rts_n); end
        n_cmp++; if (bus.overflow !== 1'b0) begin n_err++; $display("FAIL ar_ovf: got %b want 0", bus.overflow); end
        model_clear();
        @(negedge clk);
        reset = 1'b1;
        repeat (10) begin
            tick(1'b0, 8'h00, 1'b0, 1'b0);
            if (bus.unicode_available === 1'b1) stale++;
        end
        n_cmp++; if (stale != 0) begin n_err++; $display("FAIL ar_stale: got %0d pulses want 0", stale); end
        n_cmp++; if (bus.fill !== 7'd0) begin n_err++; $display("FAIL ar_fill_after: got %0d want 0", bus.fill); end
    endtask

    initial begin
        test_reset();
        test_pass_through();
        do_reset();
        test_backpressure();
        test_hysteresis();
        test_overflow();
        test_wrap();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end
endmodule
